// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: address/instruction widths and the fetch entry
// record carried from fetch into decode.
package cpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction memory port, redirect input and the decode
// handshake. master = fetch stage, slave = surrounding pipeline / memory.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic               redirect_valid_i;
  logic [ADDR_W-1:0]  redirect_pc_i;
  logic               instr_valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  instr_pc_o;
  logic               instr_ready_i;
  logic [CNT_W-1:0]   count_o;

  modport master (
    output imem_addr_o,
    input  imem_data_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    input  instr_ready_i,
    output count_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_data_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    output instr_ready_i,
    input  count_o
  );

endinterface

// File: rtl/ifq_fifo.sv
// Generic DEPTH-entry first-word-fall-through FIFO of fetch entries with a
// synchronous flush. The head is read from registered storage through the
// registered read pointer, so outputs never depend on i_deq combinationally.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_flush,
  input  logic             i_enq,
  input  fetch_entry_t     i_data,
  input  logic             i_deq,
  output fetch_entry_t     o_head,
  output logic             o_valid,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Entry storage: unreset, a stale write during flush is harmless because
  // the pointers restart at zero.
  always_ff @(posedge clk_i) begin
    if (i_enq) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_enq, i_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, drives the combinational instruction
// memory and buffers {pc, instr} pairs in an FWFT queue for decode.
// A redirect flushes the queue and reloads the PC (word aligned).
// Optional build macro IFQ_PERF_CNT_EN adds saturating stall/flush counters.
module instr_fetch_queue
  import cpu_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instr_fetch_queue_if.master bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [15:0]         flush_cnt_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              w_deq;
  logic              w_enq;
  logic              w_valid;
  logic              w_full;
  fetch_entry_t      w_head;
  fetch_entry_t      w_wr_entry;
  logic [CNT_W-1:0]  w_count;

  // A full queue still accepts a new word when the head leaves this cycle.
  assign w_deq      = w_valid & bus.instr_ready_i;
  assign w_enq      = ~bus.redirect_valid_i & (~w_full | w_deq);
  assign w_wr_entry = '{pc: r_fetch_pc, instr: bus.imem_data_i};

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_flush (bus.redirect_valid_i),
    .i_enq   (w_enq),
    .i_data  (w_wr_entry),
    .i_deq   (w_deq),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Fetch PC: redirect reloads, a successful enqueue steps, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid_i) begin
      r_fetch_pc <= align_pc(bus.redirect_pc_i);
    end else if (w_enq) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  assign bus.imem_addr_o   = r_fetch_pc;
  assign bus.instr_valid_o = w_valid;
  assign bus.instr_o       = w_head.instr;
  assign bus.instr_pc_o    = w_head.pc;
  assign bus.count_o       = w_count;

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating counters: cycles stuck full without a dequeue, and redirects.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_full && !w_deq && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.redirect_valid_i && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Fetch stage placed directly upstream of the decode/register-file stage. It owns the fetch PC and drives the address of the combinational instruction memory. It captures each returned word, together with its PC, into a small FIFO. Decode drains the FIFO through a valid/ready handshake, and a redirect from branch resolution flushes the FIFO and reloads the fetch PC.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
imem_addr_o  out  32  instruction memory address; equals fetch PC (combinational from register)
imem_data_i  in  32  instruction word for imem_addr_o, valid in the same cycle
redirect_valid_i  in  1  branch/jump taken; flush the queue and reload the PC
redirect_pc_i  in  32  redirect target; bits [1:0] forced to 0 on load
instr_valid_o  out  1  head entry valid (count != 0)
instr_o  out  32  head entry instruction
instr_pc_o  out  32  head entry PC
instr_ready_i  in  1  decode accepts the head this cycle
count_o  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_i=1 at a clock edge): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0. Outputs follow: instr_valid_o=0, count_o=0, imem_addr_o=RESET_PC. instr_o and instr_pc_o are don't-care while invalid. Reset overrides every other input, including mid-flush and mid-handshake.
- deq = instr_valid_o & instr_ready_i.
- enq = !redirect_valid_i & (count<DEPTH | deq).
  - Full with simultaneous dequeue still enqueues.
- On enq: write {fetch_pc, imem_data_i} at wr_ptr; wr_ptr++; fetch_pc += PC_STEP (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
- On !enq with no redirect: fetch_pc holds, and imem_addr_o is re-presented next cycle.
- On deq: rd_ptr++.
- count update: +1 on enq only, -1 on deq only, unchanged when both or neither.
- Redirect (priority over enq; equal priority with reset is not possible since reset wins):
  - next cycle count=0 and rd_ptr=wr_ptr=0;
  - fetch_pc={redirect_pc_i[31:2],2'b00}.
  - A deq in the redirect cycle still completes handshake-wise (decode sees the word); the entry is discarded by the flush anyway.
  - The cycle after a redirect is a fetch cycle from the new PC, so the first new entry is visible 2 cycles after redirect assertion.
- Latency: the word fetched in cycle N is at the head (if the queue was empty) with instr_valid_o=1 in cycle N+1. The first instruction after reset release is valid one cycle after the first non-reset edge.
- The queue is first-word-fall-through from registered storage; outputs are driven from the head entry with no combinational path from instr_ready_i to outputs.
- Pointers wrap modulo DEPTH.
- Back-to-back: with instr_ready_i held 1, one instruction per cycle in steady state and count stays 1.

Optional Feature:
Macro: IFQ_PERF_CNT_EN.
- Defined:
  - adds output stall_cnt_o (32 bits), which increments each cycle count==DEPTH & !deq, saturating at 32'hFFFF_FFFF;
  - adds output flush_cnt_o (16 bits), which increments on each redirect cycle, saturating;
  - both counters are cleared by reset.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg): ADDR_W=32, INSTR_W=32, and a typedef fetch_entry_t {pc[31:0], instr[31:0]}; reused by decode.
- One natural sub-module: ifq_fifo, a generic DEPTH-entry FWFT FIFO with synchronous flush, enq/deq and count. instr_fetch_queue keeps the PC register, redirect logic and optional counters.

Test Plan:
- Reset release with RESET_PC=0 and instr_ready_i=0:
  - imem_addr_o steps 0,4,8,12 then holds at 16 when count_o=4;
  - instr_pc_o=0 and instr_o equals the word stored at 0.
- instr_ready_i held 1 from reset: instr_pc_o sequence 0,4,8,... one per cycle; count_o stays 1.
- Full queue (count=4) with instr_ready_i pulsed for 1 cycle: enq and deq occur together; count_o stays 4; imem_addr_o advances 16 to 20.
- redirect_valid_i=1 with redirect_pc_i=32'h0000_0103 while count=3:
  - next cycle count_o=0, instr_valid_o=0, imem_addr_o=32'h100;
  - cycle after, instr_pc_o=32'h100.
- redirect_pc_i=32'hFFFF_FFF8 with instr_ready_i=1: instr_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_i asserted mid-stream (count=2): next cycle count_o=0, instr_valid_o=0, imem_addr_o=RESET_PC; with IFQ_PERF_CNT_EN, stall_cnt_o=0 and flush_cnt_o=0.
